// File: rtl/mont_operand_buffer.sv
// Operand staging buffer for a bank of Montgomery cores.
// Software loads operands word by word, launches cores through a control
// word, and collects results from a separate read-only region. Every core
// runs its own IDLE/SEND/WAIT/DONE handshake independently of the others.
module mont_operand_buffer #(
    parameter int NUM_OF_CORES    = 2,
    parameter int OPERAND_WIDTH   = 512,
    parameter int BRAM_ADDR_WIDTH = 10
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]             sw_addr,
    input  logic [31:0]                            sw_din,
    input  logic                                   sw_we,
    output logic [31:0]                            sw_dout,
    output logic [NUM_OF_CORES*OPERAND_WIDTH-1:0]  core_din,
    output logic [NUM_OF_CORES-1:0]                core_din_valid,
    input  logic [NUM_OF_CORES-1:0]                core_din_ready,
    input  logic [NUM_OF_CORES*OPERAND_WIDTH-1:0]  core_dout,
    input  logic [NUM_OF_CORES-1:0]                core_dout_valid,
    output logic [NUM_OF_CORES-1:0]                core_dout_ready
);

    localparam int WPC      = OPERAND_WIDTH / 32;
    localparam int NW       = NUM_OF_CORES * WPC;
    localparam int RES_BASE = 2 ** (BRAM_ADDR_WIDTH - 1);
    localparam int CTRL     = 2 ** BRAM_ADDR_WIDTH - 1;
    localparam logic [BRAM_ADDR_WIDTH-1:0] CTRL_ADDR = BRAM_ADDR_WIDTH'(CTRL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Word k of the flat buffers is word (k % WPC) of core (k / WPC), which
    // is exactly the core_din / core_dout slicing, so the input buffer can
    // drive core_din directly.
    state_t [NUM_OF_CORES-1:0] r_state;
    logic   [NW*32-1:0]        r_in_flat;
    logic   [NW*32-1:0]        r_res_flat;
    logic                      r_err;
    logic   [31:0]             r_dout;

    logic                      w_ctrl_wr;
    logic                      w_err_set;
    logic   [31:0]             w_status;
    logic   [31:0]             w_rd_data;

    // Decode control writes and detect launches aimed at busy cores.
    always_comb begin
        w_ctrl_wr = sw_we && (sw_addr == CTRL_ADDR);
        w_err_set = 1'b0;
        for (int c = 0; c < NUM_OF_CORES; c++) begin
            if (w_ctrl_wr && sw_din[c] &&
                (r_state[c] == S_SEND || r_state[c] == S_WAIT)) begin
                w_err_set = 1'b1;
            end
        end
    end

    // Status word: busy flags low, done flags from bit 16, sticky error on top.
    always_comb begin
        w_status = '0;
        for (int c = 0; c < NUM_OF_CORES; c++) begin
            w_status[c]      = (r_state[c] == S_SEND) || (r_state[c] == S_WAIT);
            w_status[16 + c] = (r_state[c] == S_DONE);
        end
        w_status[31] = r_err;
    end

    // Per-core handshake FSMs plus the sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_OF_CORES; c++) begin
                r_state[c] <= S_IDLE;
            end
            r_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_OF_CORES; c++) begin
                case (r_state[c])
                    S_IDLE: if (w_ctrl_wr && sw_din[c]) r_state[c] <= S_SEND;
                    S_SEND: if (core_din_ready[c]) r_state[c] <= S_WAIT;
                    S_WAIT: if (core_dout_valid[c]) r_state[c] <= S_DONE;
                    S_DONE: begin
                        // A relaunch wins over a clear aimed at the same core.
                        if (w_ctrl_wr && sw_din[c]) begin
                            r_state[c] <= S_SEND;
                        end else if (w_ctrl_wr && sw_din[16 + c]) begin
                            r_state[c] <= S_IDLE;
                        end
                    end
                    default: r_state[c] <= S_IDLE;
                endcase
            end
            // A new error in the same write as a clear still gets recorded.
            r_err <= (r_err && !(w_ctrl_wr && sw_din[31])) || w_err_set;
        end
    end

    // Operand writes (locked while the core is sampling) and result capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_flat  <= '0;
            r_res_flat <= '0;
        end else begin
            for (int c = 0; c < NUM_OF_CORES; c++) begin
                for (int w = 0; w < WPC; w++) begin
                    if (sw_we && (sw_addr == BRAM_ADDR_WIDTH'(c * WPC + w)) &&
                        (r_state[c] != S_SEND)) begin
                        r_in_flat[(c * WPC + w) * 32 +: 32] <= sw_din;
                    end
                    if ((r_state[c] == S_WAIT) && core_dout_valid[c]) begin
                        r_res_flat[(c * WPC + w) * 32 +: 32] <=
                            core_dout[c * OPERAND_WIDTH + w * 32 +: 32];
                    end
                end
            end
        end
    end

    // Software read mux; anything outside the three regions reads as zero.
    always_comb begin
        w_rd_data = '0;
        if (sw_addr == CTRL_ADDR) begin
            w_rd_data = w_status;
        end
        for (int k = 0; k < NW; k++) begin
            if (sw_addr == BRAM_ADDR_WIDTH'(k)) begin
                w_rd_data = r_in_flat[k * 32 +: 32];
            end
            if (sw_addr == BRAM_ADDR_WIDTH'(RES_BASE + k)) begin
                w_rd_data = r_res_flat[k * 32 +: 32];
            end
        end
    end

    // Registered read port: one cycle of latency, holds during writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (!sw_we) begin
            r_dout <= w_rd_data;
        end
    end

    assign sw_dout  = r_dout;
    assign core_din = r_in_flat;

    generate
        for (genvar gi = 0; gi < NUM_OF_CORES; gi++) begin : g_core_hs
            assign core_din_valid[gi]  = (r_state[gi] == S_SEND);
            assign core_dout_ready[gi] = (r_state[gi] == S_WAIT);
        end
    endgenerate

endmodule

// File: doc/mont_operand_buffer.md
MONT_OPERAND_BUFFER -- requirements
Module: mont_operand_buffer

Interface
REQ-001 SHALL have parameter NUM_OF_CORES, default 2, number of Montgomery core channels (1..8).
REQ-002 SHALL have parameter OPERAND_WIDTH, default 512, bits per operand; multiple of 32; WPC = OPERAND_WIDTH/32.
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default 10, software word-address width; RES_BASE = 2^(BRAM_ADDR_WIDTH-1); CTRL = 2^BRAM_ADDR_WIDTH-1; NUM_OF_CORES*WPC < RES_BASE-1 required.
REQ-004 SHALL have clk, input, 1, single clock for all logic.
REQ-005 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have sw_addr, input, BRAM_ADDR_WIDTH, software word address.
REQ-007 SHALL have sw_din, input, 32, software write data.
REQ-008 SHALL have sw_we, input, 1, software write enable.
REQ-009 SHALL have sw_dout, output, 32, registered software read data.
REQ-010 SHALL have core_din, output, NUM_OF_CORES*OPERAND_WIDTH, operand per core; core c at slice [c*OPERAND_WIDTH +: OPERAND_WIDTH].
REQ-011 SHALL have core_din_valid, output, NUM_OF_CORES, operand valid per core.
REQ-012 SHALL have core_din_ready, input, NUM_OF_CORES, core accepts operand.
REQ-013 SHALL have core_dout, input, NUM_OF_CORES*OPERAND_WIDTH, result per core, same slicing.
REQ-014 SHALL have core_dout_valid, input, NUM_OF_CORES, result valid per core.
REQ-015 SHALL have core_dout_ready, output, NUM_OF_CORES, buffer accepts result.

Function
REQ-016 Address map SHALL be: input word w of core c at c*WPC+w; result word w of core c at RES_BASE+c*WPC+w; control/status at CTRL; word w=0 maps to operand bits [31:0].
REQ-017 Each core SHALL own an independent FSM: IDLE, SEND, WAIT, DONE.
REQ-018 Write to CTRL with bit c=1 SHALL move core c from IDLE or DONE to SEND at the next clk edge; multiple bits launch multiple cores in the same cycle.
REQ-019 Launch bit for a core in SEND or WAIT SHALL be ignored and SHALL set sticky error bit; other cores in the same write still launch.
REQ-020 CTRL write bit 16+c=1 SHALL move core c from DONE to IDLE; bit 31=1 SHALL clear error; launch takes priority over clear for the same core.
REQ-021 core_din_valid[c] SHALL be 1 exactly in SEND; core_din slice SHALL be the input buffer of core c and stable while valid.
REQ-022 SEND SHALL go to WAIT on the edge where core_din_valid[c] and core_din_ready[c] are both 1; valid low the following cycle.
REQ-023 core_dout_ready[c] SHALL be 1 exactly in WAIT; on the edge with core_dout_valid[c]=1 the result buffer SHALL latch core_dout slice and FSM SHALL go to DONE.
REQ-024 core_dout_valid outside WAIT SHALL be ignored.
REQ-025 Software writes to a core's input buffer SHALL be ignored while that core is in SEND; allowed in IDLE, WAIT, DONE.
REQ-026 Software writes to the result region and to unmapped addresses SHALL be ignored.
REQ-027 Read latency SHALL be 1 cycle: sw_dout updates on the edge after sw_addr is presented (sw_we=0); unmapped addresses return 0.
REQ-028 CTRL read SHALL return bits[N-1:0]=busy (SEND or WAIT), bits[16+N-1:16]=DONE, bit31=error, others 0.
REQ-029 Cores SHALL be fully independent; completion order unconstrained.

Reset
REQ-030 resetn=0 SHALL immediately force all FSMs to IDLE, core_din_valid=0, core_dout_ready=0, sw_dout=0, error=0, and all input/result buffers to 0, including mid-transaction.
REQ-031 After resetn deasserts, the first operation SHALL be accepted on the first clk edge.

Verification (N=2, W=512, A=10, RES_BASE=512, CTRL=1023)
REQ-032 Write 0x1..0x10 to addresses 0..15, write CTRL=0x1 -> next cycle core_din_valid=2'b01, core_din[31:0]=0x1, [511:480]=0x10; held stable 5 cycles with ready=0; ready[0]=1 one cycle -> valid[0]=0, core_dout_ready[0]=1 next cycle.
REQ-033 In WAIT drive core_dout_valid[0]=1, slice word k=0xA000_0000+k -> read 512 returns 0xA000_0000, 527 returns 0xA000_000F; CTRL reads 0x0001_0000.
REQ-034 Write CTRL=0x1 while core0 in WAIT -> state unchanged, CTRL bit31=1; write CTRL=0x8000_0000 -> bit31=0.
REQ-035 Write CTRL=0x3 -> both valids high same cycle; complete core1 then core0 -> each result in own region, CTRL=0x0003_0000; write 0x0003_0000 -> CTRL=0.
REQ-036 Write address 0 with 0xDEAD during SEND -> core_din unchanged; read 1000 -> 0; assert resetn=0 in WAIT -> core_dout_ready=0 immediately, CTRL and buffers read 0 after release.
